// File: rtl/scan_pkg.sv
// Shared types and constants for the clock-synchronous scan-chain tap.
// No logic lives here. Only the frame-state encoding, the broadcast address and the counter sizing.
package scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_FULL = 3'd3,
    ST_OVER = 3'd4
  } scan_state_e;

  localparam int MAX_FIELD_W = 64;
  localparam logic [MAX_FIELD_W-1:0] BROADCAST_ADDR = '1;

  // One spare bit so the count can run past the longest legal frame and saturate.
  localparam int CNT_SAT_BITS = 1;

  function automatic int scan_cnt_w(input int addr_w, input int data_w);
    return $clog2(addr_w + data_w) + CNT_SAT_BITS;
  endfunction

endpackage

// File: rtl/scan_sync.sv
// Two-flop synchronizer for one asynchronous chain signal into clk.
// Latency is 2 clk and there is no backpressure.
module scan_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/scan_tap_sync.sv
// Scan-chain tap: oversamples TCK/TMS/TDI, decodes addr/data frames and swaps a matched project's data into the chain.
// Chain outputs lag inputs by 3 clk. outbound updates 1 clk after the synchronized TMS fall. There is no backpressure.
module scan_tap_sync
  import scan_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] RESET_VALUE  = '0,
  parameter bit                BROADCAST_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_tck,
  input  logic              i_tms,
  input  logic              i_tdi,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] inbound,
  output logic [DATA_W-1:0] outbound,
  output logic              o_tck,
  output logic              o_tms,
  output logic              o_tdo,
  output logic              selected,
  output logic              update_stb
);

  localparam int              CNT_W     = scan_cnt_w(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(ADDR_W + DATA_W - 1);

  logic w_tck_s;
  logic w_tms_s;
  logic w_tdi_s;
  logic w_tck_rise;
  logic [ADDR_W-1:0] w_addr_next;
  logic w_true_match;
  logic w_bcast_match;
  logic w_drive_rdbk;

  scan_state_e       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rdbk;
  logic              r_bcast;
  logic              r_tck_prev;

  scan_sync u_sync_tck (.clk(clk), .reset_n(reset_n), .i_d(i_tck), .o_q(w_tck_s));
  scan_sync u_sync_tms (.clk(clk), .reset_n(reset_n), .i_d(i_tms), .o_q(w_tms_s));
  scan_sync u_sync_tdi (.clk(clk), .reset_n(reset_n), .i_d(i_tdi), .o_q(w_tdi_s));

  assign w_tck_rise    = w_tck_s & ~r_tck_prev;
  // Fields arrive LSB first, so each new bit enters at the top and the register shifts right.
  assign w_addr_next   = {w_tdi_s, r_addr[ADDR_W-1:1]};
  assign w_true_match  = (w_addr_next == address);
  assign w_bcast_match = BROADCAST_EN && (w_addr_next == BROADCAST_ADDR[ADDR_W-1:0]);
  assign w_drive_rdbk  = ((r_state == ST_DATA) || (r_state == ST_FULL)) && selected;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rdbk     <= '0;
      r_bcast    <= 1'b0;
      r_tck_prev <= 1'b0;
      outbound   <= RESET_VALUE;
      o_tck      <= 1'b0;
      o_tms      <= 1'b0;
      o_tdo      <= 1'b0;
      selected   <= 1'b0;
      update_stb <= 1'b0;
    end else begin
      r_tck_prev <= w_tck_s;
      o_tck      <= w_tck_s;
      o_tms      <= w_tms_s;
      o_tdo      <= w_drive_rdbk ? r_rdbk[0] : w_tdi_s;
      update_stb <= 1'b0;

      if (r_state == ST_IDLE) begin
        r_cnt    <= '0;
        r_addr   <= '0;
        r_data   <= '0;
        r_rdbk   <= '0;
        r_bcast  <= 1'b0;
        selected <= 1'b0;
        if (w_tms_s) begin
          r_state <= ST_ADDR;
        end
      end else if (!w_tms_s) begin
        // Frame end wins over a coincident TCK rise; only an exact-length frame commits.
        r_state  <= ST_IDLE;
        selected <= 1'b0;
        r_bcast  <= 1'b0;
        if ((r_state == ST_FULL) && (selected || r_bcast)) begin
          outbound   <= r_data;
          update_stb <= 1'b1;
        end
      end else if (w_tck_rise) begin
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + 1'b1;
        end
        case (r_state)
          ST_ADDR: begin
            r_addr <= w_addr_next;
            if (r_cnt == LAST_ADDR) begin
              r_state  <= ST_DATA;
              selected <= w_true_match;
              r_bcast  <= w_bcast_match;
              if (w_true_match) begin
                r_rdbk <= inbound;
              end
            end
          end
          ST_DATA: begin
            r_data <= {w_tdi_s, r_data[DATA_W-1:1]};
            if (selected) begin
              r_rdbk <= {1'b0, r_rdbk[DATA_W-1:1]};
            end
            if (r_cnt == LAST_DATA) begin
              r_state <= ST_FULL;
            end
          end
          ST_FULL: r_state <= ST_OVER;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_tap_sync.sv
// Directed frames into two taps (broadcast enabled / disabled) checked against a delay-line frame model.
// The model predicts chain outputs as inputs delayed 3 clk, and predicts outbound from whole-frame rules.
module tb_scan_tap_sync;

  localparam int N = 4096;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_tck, i_tms, i_tdi;
  logic [7:0] address;
  logic [7:0] inbound;

  logic [7:0] a_out, b_out;
  logic       a_tck, a_tms, a_tdo, a_sel, a_stb;
  logic       b_tck, b_tms, b_tdo, b_sel, b_stb;

  scan_tap_sync #(.ADDR_W(8), .DATA_W(8), .RESET_VALUE(8'h00), .BROADCAST_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .i_tck(i_tck), .i_tms(i_tms), .i_tdi(i_tdi),
    .address(address), .inbound(inbound), .outbound(a_out), .o_tck(a_tck), .o_tms(a_tms),
    .o_tdo(a_tdo), .selected(a_sel), .update_stb(a_stb));

  scan_tap_sync #(.ADDR_W(8), .DATA_W(8), .RESET_VALUE(8'h00), .BROADCAST_EN(1'b0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .i_tck(i_tck), .i_tms(i_tms), .i_tdi(i_tdi),
    .address(address), .inbound(inbound), .outbound(b_out), .o_tck(b_tck), .o_tms(b_tms),
    .o_tdo(b_tdo), .selected(b_sel), .update_stb(b_stb));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  int stb_cnt  = 0;
  logic [7:0] cap;

  // Model state describing the current input cycle, recorded each cycle into history.
  logic [7:0] m_out = 8'h00, m_out_nb = 8'h00, m_inb = 8'h00;
  logic       m_stb = 1'b0, m_stb_nb = 1'b0, m_sel = 1'b0, m_mf = 1'b0;
  int         m_idx = -1;

  logic       hist_tck [N];
  logic       hist_tms [N];
  logic       hist_tdi [N];
  logic       hist_sel [N];
  logic       hist_mf  [N];
  logic       hist_stb [N];
  logic       hist_stb_nb [N];
  logic [7:0] hist_out [N];
  logic [7:0] hist_out_nb [N];
  logic [7:0] hist_inb [N];
  int         hist_idx [N];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      int h;
      int p;
      @(negedge clk);
      h = cyc % N;
      hist_tck[h] = i_tck;  hist_tms[h] = i_tms;  hist_tdi[h] = i_tdi;
      hist_sel[h] = m_sel;  hist_mf[h]  = m_mf;   hist_idx[h] = m_idx;
      hist_stb[h] = m_stb;  hist_stb_nb[h] = m_stb_nb;
      hist_out[h] = m_out;  hist_out_nb[h] = m_out_nb; hist_inb[h] = m_inb;
      if (chk_en && cyc >= 3) begin
        p = (cyc - 3) % N;
        check("o_tck", a_tck, hist_tck[p]);
        check("o_tms", a_tms, hist_tms[p]);
        check("nb_o_tck", b_tck, hist_tck[p]);
        check("selected", a_sel, hist_sel[p]);
        check("nb_selected", b_sel, hist_sel[p]);
        check("outbound", a_out, hist_out[p]);
        check("nb_outbound", b_out, hist_out_nb[p]);
        check("update_stb", a_stb, hist_stb[p]);
        check("nb_update_stb", b_stb, hist_stb_nb[p]);
        if (hist_mf[p]) begin
          if (hist_idx[p] >= 8 && hist_idx[p] < 16) begin
            logic [7:0] ib;
            ib = hist_inb[p];
            check("tdo_readback", a_tdo, ib[hist_idx[p]-8]);
            cap[hist_idx[p]-8] = a_tdo;
          end else if (hist_idx[p] >= 0 && hist_idx[p] < 8) begin
            check("tdo_addr_pass", a_tdo, hist_tdi[p]);
          end
        end else begin
          check("tdo_pass", a_tdo, hist_tdi[p]);
          check("nb_tdo_pass", b_tdo, hist_tdi[p]);
        end
        if (a_stb) stb_cnt++;
      end
      cyc++;
    end
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset_n = 1'b0;
    i_tck = 1'b0; i_tms = 1'b0; i_tdi = 1'b0;
    m_out = 8'h00; m_out_nb = 8'h00; m_sel = 1'b0; m_mf = 1'b0;
    m_idx = -1; m_stb = 1'b0; m_stb_nb = 1'b0;
    @(negedge clk);
    check("rst_outbound", a_out, 8'h00);
    check("rst_nb_outbound", b_out, 8'h00);
    check("rst_o_tck", a_tck, 1'b0);
    check("rst_o_tms", a_tms, 1'b0);
    check("rst_o_tdo", a_tdo, 1'b0);
    check("rst_selected", a_sel, 1'b0);
    check("rst_update_stb", a_stb, 1'b0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk_en = 1'b1;
  endtask

  // abort_at >= 0 stops after that many bits with TMS still high.
  task automatic send_frame(input logic [7:0] addr, input logic [7:0] data,
                            input int nbits, input int abort_at);
    bit mf;
    mf = (addr == 8'h03) && (nbits >= 8);
    m_inb = inbound;
    m_mf  = mf;
    i_tms = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < nbits; i++) begin
      if (abort_at >= 0 && i == abort_at) return;
      i_tdi = (i < 8) ? addr[i] : (i < 16) ? data[i-8] : 1'b1;
      i_tck = 1'b0;
      repeat (5) tick();
      i_tck = 1'b1;
      m_idx = i;
      if (i == 7 && mf) m_sel = 1'b1;
      tick();
      m_idx = -1;
      repeat (4) tick();
    end
    i_tck = 1'b0;
    i_tdi = 1'b0;
    repeat (3) tick();
    i_tms = 1'b0;
    m_sel = 1'b0;
    if (nbits == 16) begin
      if (addr == 8'h03) begin
        m_out = data; m_out_nb = data; m_stb = 1'b1; m_stb_nb = 1'b1;
      end else if (addr == 8'hFF) begin
        m_out = data; m_stb = 1'b1;
      end
    end
    tick();
    m_stb = 1'b0;
    m_stb_nb = 1'b0;
    m_mf = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    address = 8'h03;
    inbound = 8'h3C;
    cap = 8'h00;
    do_reset();

    // Matched frame
    stb_cnt = 0;
    send_frame(8'h03, 8'hA5, 16, -1);
    check("matched_outbound", a_out, 8'hA5);
    check("matched_stb_count", stb_cnt, 1);
    check("matched_tdo_bits", cap, 8'h3C);

    // Unmatched frame
    stb_cnt = 0;
    send_frame(8'h04, 8'hA5, 16, -1);
    check("unmatched_outbound", a_out, 8'hA5);
    check("unmatched_stb_count", stb_cnt, 0);

    // Broadcast frame
    stb_cnt = 0;
    send_frame(8'hFF, 8'h5A, 16, -1);
    check("bcast_en_outbound", a_out, 8'h5A);
    check("bcast_dis_outbound", b_out, 8'hA5);
    check("bcast_stb_count", stb_cnt, 1);

    // Short and long frames
    stb_cnt = 0;
    send_frame(8'h03, 8'h0F, 12, -1);
    check("short_outbound", a_out, 8'h5A);
    check("short_nb_outbound", b_out, 8'hA5);
    check("short_selected", a_sel, 1'b0);
    send_frame(8'h03, 8'h0F, 17, -1);
    check("long_outbound", a_out, 8'h5A);
    check("long_nb_outbound", b_out, 8'hA5);
    check("bad_len_stb_count", stb_cnt, 0);

    // Reset mid data phase, then a clean frame
    send_frame(8'h03, 8'h55, 16, 11);
    do_reset();
    stb_cnt = 0;
    send_frame(8'h03, 8'h81, 16, -1);
    check("post_reset_outbound", a_out, 8'h81);
    check("post_reset_nb_outbound", b_out, 8'h81);
    check("post_reset_stb_count", stb_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
